// File: rtl/mux_n_pkg.sv
// mux_n_pkg: shared types, defaults and the round-robin pick function for mux_n_pipe.
//   modo_e     : operating mode (MODO_FIXO fixed select, MODO_RR round-robin)
//   rr_pick_t  : {found, idx} result of a round-robin scan
//   rr_pick()  : first valid index scanning upward from ptr+1, wrapping n-1 -> 0
// Optional feature macro used by the design: MUX_N_PIPE_PARITY_EN.
package mux_n_pkg;

   localparam int unsigned NDefault = 8;
   localparam int unsigned WDefault = 32;

   // Widest supported configuration; rr_pick works on vectors padded to this size.
   localparam int unsigned MaxN  = 16;
   localparam int unsigned MaxSw = 4;
   localparam int unsigned PosW  = MaxSw + 1;

   typedef enum logic {
      MODO_FIXO = 1'b0,
      MODO_RR   = 1'b1
   } modo_e;

   typedef struct packed {
      logic             found;
      logic [MaxSw-1:0] idx;
   } rr_pick_t;

   // Only the low n bits of valid are meaningful; ptr must be < n.
   function automatic rr_pick_t rr_pick(input logic [MaxN-1:0]  valid,
                                        input logic [MaxSw-1:0] ptr,
                                        input int unsigned      n);
      rr_pick_t       res;
      logic [PosW-1:0] pos;
      res = '0;
      for (int unsigned k = 1; k <= MaxN; k++) begin
         // ptr + k < 2n, so one conditional subtract performs the wrap.
         pos = {1'b0, ptr} + PosW'(k);
         if (pos >= PosW'(n)) pos = pos - PosW'(n);
         if ((k <= n) && !res.found && valid[pos[MaxSw-1:0]]) begin
            res.found = 1'b1;
            res.idx   = pos[MaxSw-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// mux_n_pipe_if: channel-side and output-side handshake bus of mux_n_pipe.
//   entradas   N*W  channel data, channel i at [i*W +: W]
//   in_valid   N    per-channel valid        in_ready  N  per-channel ready (one-hot or zero)
//   saidaMux   W    registered output word   out_valid 1  output register holds a word
//   out_ready  1    consumer accepts         out_sel   SW channel index of saidaMux
//   out_parity 1    even parity of saidaMux (only with MUX_N_PIPE_PARITY_EN defined)
// Modports: slave = the mux, master = the environment driving channels and consuming output.
interface mux_n_pipe_if #(
   parameter int unsigned N = mux_n_pkg::NDefault,
   parameter int unsigned W = mux_n_pkg::WDefault
);
   localparam int unsigned SW = $clog2(N);

   logic [N*W-1:0] entradas;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   saidaMux;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_sel;
`ifdef MUX_N_PIPE_PARITY_EN
   logic           out_parity;

   modport slave (
      input  entradas, in_valid, out_ready,
      output in_ready, saidaMux, out_valid, out_sel, out_parity
   );
   modport master (
      output entradas, in_valid, out_ready,
      input  in_ready, saidaMux, out_valid, out_sel, out_parity
   );
`else
   modport slave (
      input  entradas, in_valid, out_ready,
      output in_ready, saidaMux, out_valid, out_sel
   );
   modport master (
      output entradas, in_valid, out_ready,
      input  in_ready, saidaMux, out_valid, out_sel
   );
`endif

endinterface

// File: rtl/mux_n_rr_arb.sv
// mux_n_rr_arb: combinational round-robin candidate finder.
//   i_valid  N   request vector
//   i_ptr    SW  last granted index; scanning starts at i_ptr+1
//   o_onehot N   one-hot of the candidate, zero when nothing is valid
//   o_idx    SW  candidate index (meaningful only when o_found)
//   o_found  1   at least one request is valid
module mux_n_rr_arb
   import mux_n_pkg::*;
#(
   parameter  int unsigned N  = NDefault,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [SW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [SW-1:0] o_idx,
   output logic          o_found
);

   logic [MaxN-1:0]  w_valid_pad;
   logic [MaxSw-1:0] w_ptr_pad;
   rr_pick_t         w_pick;

   assign w_valid_pad = MaxN'(i_valid);
   assign w_ptr_pad   = MaxSw'(i_ptr);
   assign w_pick      = rr_pick(w_valid_pad, w_ptr_pad, N);

   assign o_found = w_pick.found;
   assign o_idx   = w_pick.idx[SW-1:0];

   // Decode against the full-width index so no aliasing can occur.
   always_comb begin
      o_onehot = '0;
      for (int unsigned i = 0; i < N; i++) begin
         o_onehot[i] = w_pick.found && (w_pick.idx == MaxSw'(i));
      end
   end

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way, W-bit registered multiplexer with valid/ready on every channel.
//   clk      in   clock, all state on rising edge
//   reset_n  in   asynchronous active-low reset
//   modo     in   0 fixed select (select register), 1 round-robin over valid channels
//   sel_in   in   new fixed select value; sel_load loads it when sel_in < N
//   sel_err  out  sticky flag: an out-of-range select load was attempted
//   bus      slave modport of mux_n_pipe_if (channel data/handshake, registered output)
// Optional feature: define MUX_N_PIPE_PARITY_EN to add bus.out_parity, the XOR-reduce of
// the captured word, registered alongside saidaMux.
module mux_n_pipe
   import mux_n_pkg::*;
#(
   parameter  int unsigned N  = NDefault,
   parameter  int unsigned W  = WDefault,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          modo,
   input  logic [SW-1:0] sel_in,
   input  logic          sel_load,
   output logic          sel_err,
   mux_n_pipe_if.slave   bus
);

   logic [SW-1:0] r_sel;
   logic [SW-1:0] r_ptr;
   logic [W-1:0]  r_data;
   logic [SW-1:0] r_out_sel;
   logic          r_valid;
   logic          r_sel_err;
`ifdef MUX_N_PIPE_PARITY_EN
   logic          r_parity;
`endif

   modo_e         w_modo;
   logic          w_cap_ok;
   logic [N-1:0]  w_rr_onehot;
   logic [SW-1:0] w_rr_idx;
   logic          w_rr_found;
   logic [N-1:0]  w_ready;
   logic [SW-1:0] w_cand;
   logic          w_take;
   logic [W-1:0]  w_cand_data;
   logic          w_sel_ok;

   assign w_modo   = modo_e'(modo);
   assign w_cap_ok = !r_valid || bus.out_ready;
   assign w_sel_ok = (32'(sel_in) < N);

   mux_n_rr_arb #(
      .N (N)
   ) u_rr_arb (
      .i_valid  (bus.in_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_rr_onehot),
      .o_idx    (w_rr_idx),
      .o_found  (w_rr_found)
   );

   always_comb begin
      w_ready = '0;
      w_cand  = r_sel;
      unique case (w_modo)
         MODO_FIXO: begin
            w_cand = r_sel;
            if (w_cap_ok) w_ready = N'(1) << r_sel;
         end
         MODO_RR: begin
            w_cand = w_rr_idx;
            if (w_cap_ok && w_rr_found) w_ready = w_rr_onehot;
         end
         default: ;
      endcase
      // No channel may see ready while the block is held in reset.
      if (!reset_n) w_ready = '0;
      w_take = |(w_ready & bus.in_valid);
   end

   assign w_cand_data = bus.entradas[w_cand*W +: W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel     <= '0;
         r_ptr     <= SW'(N - 1);
         r_data    <= '0;
         r_out_sel <= '0;
         r_valid   <= 1'b0;
         r_sel_err <= 1'b0;
`ifdef MUX_N_PIPE_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         // Out-of-range loads are rejected outright rather than truncated.
         if (sel_load) begin
            if (w_sel_ok) r_sel     <= sel_in;
            else          r_sel_err <= 1'b1;
         end

         if (w_take) begin
            r_data    <= w_cand_data;
            r_out_sel <= w_cand;
            r_valid   <= 1'b1;
`ifdef MUX_N_PIPE_PARITY_EN
            r_parity  <= ^w_cand_data;
`endif
            if (w_modo == MODO_RR) r_ptr <= w_cand;
         end else if (bus.out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.saidaMux   = r_data;
   assign bus.out_valid  = r_valid;
   assign bus.out_sel    = r_out_sel;
   assign sel_err        = r_sel_err;
`ifdef MUX_N_PIPE_PARITY_EN
   assign bus.out_parity = r_parity;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed, table-driven bench for mux_n_pipe (N=8 and N=6 instances).
module tb_mux_n_pipe;

   logic clk;
   logic reset_n;

   logic       modo8, ld8, err8;
   logic [2:0] sel8;
   logic       modo6, ld6, err6;
   logic [2:0] sel6;

   mux_n_pipe_if #(.N(8), .W(32)) bus8 ();
   mux_n_pipe_if #(.N(6), .W(32)) bus6 ();

   mux_n_pipe #(.N(8), .W(32)) u_dut8 (
      .clk      (clk),
      .reset_n  (reset_n),
      .modo     (modo8),
      .sel_in   (sel8),
      .sel_load (ld8),
      .sel_err  (err8),
      .bus      (bus8)
   );

   mux_n_pipe #(.N(6), .W(32)) u_dut6 (
      .clk      (clk),
      .reset_n  (reset_n),
      .modo     (modo6),
      .sel_in   (sel6),
      .sel_load (ld6),
      .sel_err  (err6),
      .bus      (bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        modo;
      logic [2:0]  sel_in;
      logic        sel_load;
      logic [7:0]  in_valid;
      logic        out_ready;
      logic [7:0]  exp_ready;
      logic        exp_ov;
      logic [2:0]  exp_sel;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NV = 17;
   vec_t vec [NV];

   initial begin
      // Fixed mode, select load, round-robin, backpressure, mode switches.
      vec[0]  = '{1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 32'hDEADBEEF};
      vec[1]  = '{1'b0, 3'd5, 1'b1, 8'h21, 1'b1, 8'h01, 1'b1, 3'd0, 32'hDEADBEEF};
      vec[2]  = '{1'b0, 3'd0, 1'b0, 8'h21, 1'b1, 8'h20, 1'b1, 3'd5, 32'h00000005};
      vec[3]  = '{1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 8'h20, 1'b0, 3'd5, 32'h00000005};
      vec[4]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h01, 1'b1, 3'd0, 32'hDEADBEEF};
      vec[5]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h04, 1'b1, 3'd2, 32'h22222222};
      vec[6]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h80, 1'b1, 3'd7, 32'h77777777};
      vec[7]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h01, 1'b1, 3'd0, 32'hDEADBEEF};
      vec[8]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h04, 1'b1, 3'd2, 32'h22222222};
      vec[9]  = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd2, 32'h22222222};
      vec[10] = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd2, 32'h22222222};
      vec[11] = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b0, 8'h00, 1'b1, 3'd2, 32'h22222222};
      vec[12] = '{1'b1, 3'd0, 1'b0, 8'h85, 1'b1, 8'h80, 1'b1, 3'd7, 32'h77777777};
      vec[13] = '{1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 32'h77777777};
      vec[14] = '{1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd7, 32'h77777777};
      vec[15] = '{1'b0, 3'd0, 1'b0, 8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 32'h00000005};
      // Pointer was left at 7 by the last RR grant; fixed-mode captures must not move it.
      vec[16] = '{1'b1, 3'd0, 1'b0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 32'hDEADBEEF};

      bus8.entradas = {32'h77777777, 32'h66666666, 32'h00000005, 32'h44444444,
                       32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
      bus6.entradas = {32'h000000C5, 32'h000000C4, 32'h000000C3, 32'h000000C2,
                       32'h000000C1, 32'h00000007};

      reset_n = 1'b0;
      modo8 = 1'b0; sel8 = 3'd0; ld8 = 1'b0;
      bus8.in_valid = 8'h01; bus8.out_ready = 1'b1;
      modo6 = 1'b0; sel6 = 3'd0; ld6 = 1'b0;
      bus6.in_valid = 6'h00; bus6.out_ready = 1'b1;

      // Everything quiet while held in reset, even with a valid channel.
      #3;
      chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst_saidaMux",  bus8.saidaMux,       32'd0);
      chk("rst_out_sel",   32'(bus8.out_sel),   32'd0);
      chk("rst_sel_err",   32'(err8),           32'd0);
      chk("rst_in_ready",  32'(bus8.in_ready),  32'd0);
      chk("rst6_sel_err",  32'(err6),           32'd0);
`ifdef MUX_N_PIPE_PARITY_EN
      chk("rst_parity",    32'(bus8.out_parity), 32'd0);
`endif
      @(posedge clk); #3;
      chk("rst_hold_valid", 32'(bus8.out_valid), 32'd0);

      bus8.in_valid = 8'h00;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         modo8 = vec[i].modo; sel8 = vec[i].sel_in; ld8 = vec[i].sel_load;
         bus8.in_valid = vec[i].in_valid; bus8.out_ready = vec[i].out_ready;
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), 32'(bus8.in_ready), 32'(vec[i].exp_ready));
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), 32'(bus8.out_valid), 32'(vec[i].exp_ov));
         chk($sformatf("v%0d_out_sel", i),   32'(bus8.out_sel),   32'(vec[i].exp_sel));
         chk($sformatf("v%0d_saidaMux", i),  bus8.saidaMux,       vec[i].exp_data);
`ifdef MUX_N_PIPE_PARITY_EN
         chk($sformatf("v%0d_parity", i), 32'(bus8.out_parity), 32'(^vec[i].exp_data));
`endif
      end
      ld8 = 1'b0;
      chk("dut8_no_sel_err", 32'(err8), 32'd0);

      // Asynchronous reset between edges while a word is held.
      modo8 = 1'b1; bus8.in_valid = 8'h85; bus8.out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("async_saidaMux",  bus8.saidaMux,       32'd0);
      chk("async_out_sel",   32'(bus8.out_sel),   32'd0);
      chk("async_in_ready",  32'(bus8.in_ready),  32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rr_restart_sel",  32'(bus8.out_sel),   32'd0);
      chk("rr_restart_data", bus8.saidaMux,       32'hDEADBEEF);
      chk("rr_restart_ov",   32'(bus8.out_valid), 32'd1);
      bus8.in_valid = 8'h00;

      // N=6: out-of-range select load is rejected and flagged.
      modo6 = 1'b0; sel6 = 3'd7; ld6 = 1'b1; bus6.in_valid = 6'b001000;
      @(negedge clk);
      chk("n6_ld7_in_ready", 32'(bus6.in_ready), 32'h01);
      @(posedge clk); #1;
      chk("n6_ld7_err",   32'(err6),            32'd1);
      chk("n6_ld7_ov",    32'(bus6.out_valid),  32'd0);
      ld6 = 1'b0;
      @(negedge clk);
      chk("n6_no_alias_ready", 32'(bus6.in_ready), 32'h01);
      @(posedge clk); #1;
      chk("n6_no_alias_ov", 32'(bus6.out_valid), 32'd0);
      sel6 = 3'd2; ld6 = 1'b1; bus6.in_valid = 6'b000001;
      @(negedge clk);
      chk("n6_ld2_in_ready", 32'(bus6.in_ready), 32'h01);
      @(posedge clk); #1;
      chk("n6_ch0_data",  bus6.saidaMux,        32'h00000007);
      chk("n6_ch0_sel",   32'(bus6.out_sel),    32'd0);
      chk("n6_err_stick", 32'(err6),            32'd1);
`ifdef MUX_N_PIPE_PARITY_EN
      chk("n6_parity_7",  32'(bus6.out_parity), 32'd1);
`endif
      ld6 = 1'b0; bus6.in_valid = 6'b000100;
      @(negedge clk);
      chk("n6_sel2_in_ready", 32'(bus6.in_ready), 32'h04);
      @(posedge clk); #1;
      chk("n6_ch2_data",  bus6.saidaMux,     32'h000000C2);
      chk("n6_ch2_sel",   32'(bus6.out_sel), 32'd2);
      chk("n6_err_stick2", 32'(err6),        32'd1);
      bus6.in_valid = 6'b000000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-way, W-bit registered multiplexer with valid/ready handshake on every input channel and on the output.
- Generalises the fixed 8x32 combinational datapath mux.
- Two modes: fixed select from a loadable select register, and round-robin scan across valid channels.
- Feeds MIPS datapath/writeback paths where multiple sources compete for one consumer.

Parameters:
- N, 8: number of input channels (2..16).
- W, 32: data width in bits.
- SW, $clog2(N): select width, derived; not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- modo  in  1  0 = fixed select, 1 = round-robin. Sampled every cycle.
- sel_in  in  SW  new fixed select value.
- sel_load  in  1  load sel_in into select register.
- entradas  in  N*W  channel data, flattened; channel i is bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready, one-hot or zero.
- saidaMux  out  W  registered output data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts.
- out_sel  out  SW  channel index of the word in saidaMux.
- sel_err  out  1  sticky: an out-of-range select load was attempted.

Behaviour:
- Reset, asynchronous, while reset_n = 0:
  - saidaMux = 0, out_valid = 0, out_sel = 0, sel_err = 0.
  - Select register = 0; round-robin pointer = N-1, so channel 0 has first priority.
  - in_ready = 0.
  - Reset mid-transfer drops the held word; no partial state survives.
- Capture condition: `cap_ok = !out_valid || out_ready`.
- Select register:
  - On sel_load, if sel_in < N, the register takes sel_in on the next edge.
  - If sel_in >= N, the register is unchanged and sel_err sets. It stays set until reset.
  - Out-of-range values never alias onto lower channels.
- Fixed mode (modo = 0), candidate c = select register:
  - in_ready[c] = cap_ok.
  - Transfer when in_valid[c] && in_ready[c]: saidaMux <= entradas[c], out_sel <= c, out_valid <= 1 on the next edge.
  - The candidate uses the register value before any same-cycle sel_load takes effect, so a load applies from the next cycle.
- Round-robin mode (modo = 1):
  - Candidate = first index with in_valid set, scanning upward from pointer+1 and wrapping N-1 -> 0.
  - in_ready = one-hot of the candidate when cap_ok, else 0.
  - On transfer, pointer <= candidate.
  - If no in_valid bit is set, in_ready = 0 and there is no capture.
- Output side:
  - If out_valid && out_ready and there is no new capture, out_valid <= 0 next edge; saidaMux and out_sel hold their values.
  - If both happen in the same cycle, the output is replaced back-to-back: full throughput, 1 word/cycle.
  - If out_valid && !out_ready, saidaMux and out_sel are stable and in_ready = 0.
- Latency: 1 cycle from input handshake to out_valid.
- Mode change: takes effect on the cycle it is seen. The pointer is kept across mode switches; the held output word is unaffected.
- Internal state: selection logic is combinational; only the select register, pointer, output register and sel_err are state.

Optional Feature:
- Macro: MUX_N_PIPE_PARITY_EN.
- Defined:
  - Extra output port `out_parity` (1 bit), registered with saidaMux.
  - out_parity = even parity (XOR-reduce) of the captured word; reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mux_n_pkg:
  - typedef for the mode enum: MODO_FIXO = 0, MODO_RR = 1.
  - Constants for default N and W.
  - Function `rr_pick(valid, ptr)` returning found flag and index.
- One sub-module: mux_n_rr_arb, the combinational round-robin candidate finder (N-bit valid + pointer -> one-hot + index + found).

Test Plan:
- Reset release, modo = 0, select 0, in_valid = 8'h01, entradas[0] = 32'hDEADBEEF, out_ready = 1 -> next edge: out_valid = 1, saidaMux = DEADBEEF, out_sel = 0; all outputs were 0 during reset.
- sel_load with sel_in = 5, then in_valid[5] = 1, entradas[5] = 32'h5 -> capture of 32'h5 one cycle after the load cycle; the load cycle itself still muxes channel 0.
- Out-of-range load: N = 6, sel_in = 7, sel_load = 1 -> sel_err = 1 (sticky across later valid loads); select register unchanged; no capture from channels 7 or 3.
- Round-robin: modo = 1, in_valid = 8'b1000_0101 held, out_ready = 1 -> out_sel sequence 0, 2, 7, 0, 2, … on consecutive cycles, one word per cycle.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> saidaMux stable, in_ready = 0; when out_ready rises, the pending channel is captured that cycle with no bubble.
- Async reset asserted mid-stream between clock edges -> out_valid drops immediately; after release, round-robin restarts from channel 0; with MUX_N_PIPE_PARITY_EN defined, out_parity for 32'h00000007 = 1.
